// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-port scheduler.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // Scheduler state encoding
  localparam logic CLEAR = 1'b0;
  localparam logic RUN   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_valid
);

  int            idx;
  logic [PW-1:0] sel;

  // Walk the requesters starting at ptr and latch the first one found
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = idx[PW-1:0];
      if (!gnt_valid && req[sel]) begin
        gnt[sel]  = 1'b1;
        gnt_idx   = sel;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_sched.sv
// Owns the register file's single write port. After reset, or on clr_start,
// it zeroes x1..x31 one per cycle; otherwise it grants one writeback
// requester per cycle in round-robin order and registers the write.
module rf_wr_sched #(
  parameter int N_REQ = 3,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_a3,
  output logic [XLEN-1:0]       rf_wd3
);
  import rf_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic            state;
  logic [AW-1:0]   clr_idx;
  logic            clr_fin;   // last clear write issued; finish next cycle
  logic [PW-1:0]   rr_ptr;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             accept;
  logic [AW-1:0]    sel_addr;
  logic [XLEN-1:0]  sel_data;
  logic [PW-1:0]    nxt_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grants are only exposed in RUN and never in the cycle a clear is requested
  always_comb begin
    accept    = (state == RUN) && !clr_start && gnt_valid;
    req_ready = accept ? gnt : '0;
    clr_busy  = (state == CLEAR);
    sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    sel_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];
    nxt_ptr   = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Clear sequencing, round-robin pointer and the registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_idx  <= AW'(1);
      clr_fin  <= 1'b0;
      rr_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (state == CLEAR) begin
        if (clr_fin) begin
          rf_we    <= 1'b0;
          clr_fin  <= 1'b0;
          clr_done <= 1'b1;
          state    <= RUN;
        end else begin
          rf_we  <= 1'b1;
          rf_a3  <= clr_idx;
          rf_wd3 <= '0;
          if (clr_idx == AW'(NREG-1)) begin
            clr_idx <= AW'(1);
            clr_fin <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
      end else if (clr_start) begin
        rf_we <= 1'b0;
        state <= CLEAR;
      end else if (accept) begin
        // x0 is hardwired: the transfer is consumed but nothing is written
        rf_we  <= |sel_addr;
        rf_a3  <= sel_addr;
        rf_wd3 <= sel_data;
        rr_ptr <= nxt_ptr;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule
